// File: rtl/stopwatch_core_pkg.sv
// rtl/stopwatch_core_pkg.sv - shared state encoding, BCD field layout and clamp helpers
package stopwatch_core_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } sw_state_e;

  localparam int         CS_LSB  = 0;
  localparam int         SEC_LSB = 8;
  localparam int         MIN_LSB = 16;
  localparam logic [7:0] CS_MAX  = 8'h99;
  localparam logic [7:0] SEC_MAX = 8'h59;

  function automatic logic [3:0] clamp_nib(input logic [3:0] n, input logic [3:0] lim);
    return (n > lim) ? lim : n;
  endfunction

  // Per-digit clamp; correct for fields whose max digits are each the digit ceiling.
  function automatic logic [7:0] clamp_pair(input logic [7:0] v, input logic [7:0] max);
    return {clamp_nib(v[7:4], max[7:4]), clamp_nib(v[3:0], max[3:0])};
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit_pair.sv
// rtl/stopwatch_core_bcd_digit_pair.sv - two-digit BCD up/down counter with carry/borrow chain
module bcd_digit_pair #(
  parameter logic [7:0] MAX_BCD = 8'h99
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       ld_i,
  input  logic [7:0] ld_val_i,
  input  logic       en_i,
  input  logic       down_i,
  output logic [7:0] val_o,
  output logic       co_o
);

  logic [7:0] val_q;
  logic [7:0] val_d;
  logic [7:0] step_val;

  always_comb begin
    step_val = val_q;
    if (down_i) begin
      if (val_q == 8'h00)             step_val = MAX_BCD;
      else if (val_q[3:0] == 4'd0)    step_val = {val_q[7:4] - 4'd1, 4'd9};
      else                            step_val = {val_q[7:4], val_q[3:0] - 4'd1};
    end else begin
      if (val_q == MAX_BCD)           step_val = 8'h00;
      else if (val_q[3:0] == 4'd9)    step_val = {val_q[7:4] + 4'd1, 4'd0};
      else                            step_val = {val_q[7:4], val_q[3:0] + 4'd1};
    end
  end

  always_comb begin
    val_d = val_q;
    if (clr_i)     val_d = 8'h00;
    else if (ld_i) val_d = ld_val_i;
    else if (en_i) val_d = step_val;
  end

  assign co_o  = en_i & (down_i ? (val_q == 8'h00) : (val_q == MAX_BCD));
  assign val_o = val_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) val_q <= 8'h00;
    else       val_q <= val_d;
  end

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - MM:SS.CC BCD stopwatch datapath and run sequencer
// Lap capture register exists only when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
  parameter logic [7:0] MAX_MIN_BCD = 8'h59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce100,
  input  logic        clr,
  input  logic        ld,
  input  logic        dir,
  input  logic        run,
  input  logic [23:0] load_bcd,
  input  logic        lap,
  output logic [23:0] time_bcd,
  output logic [23:0] lap_bcd,
  output logic        zero,
  output logic        running,
  output logic        done,
  output logic        wrap
);
  import stopwatch_core_pkg::*;

  sw_state_e  state_q, state_d;
  logic       done_q, done_d;
  logic       wrap_q, wrap_d;
  logic [7:0] cs_ld, sec_ld, min_san, min_ld;
  logic       tick, count_en, is_one;
  logic       cs_co, sec_co, min_co;

  assign cs_ld   = clamp_pair(load_bcd[CS_LSB +: 8], CS_MAX);
  assign sec_ld  = clamp_pair(load_bcd[SEC_LSB +: 8], SEC_MAX);
  assign min_san = {clamp_nib(load_bcd[MIN_LSB + 4 +: 4], 4'd9), clamp_nib(load_bcd[MIN_LSB +: 4], 4'd9)};
  assign min_ld  = (min_san > MAX_MIN_BCD) ? MAX_MIN_BCD : min_san;

  assign zero   = (time_bcd == 24'h000000);
  assign is_one = (time_bcd == 24'h000001);

  // A pause, clear or load in the same cycle swallows the tick.
  assign tick     = (state_q == RUNNING) & run & ce100 & ~clr & ~ld;
  assign count_en = tick & ~(dir & zero);

  bcd_digit_pair #(.MAX_BCD(CS_MAX)) u_cs (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .ld_i(ld), .ld_val_i(cs_ld),
    .en_i(count_en), .down_i(dir), .val_o(time_bcd[CS_LSB +: 8]), .co_o(cs_co)
  );

  bcd_digit_pair #(.MAX_BCD(SEC_MAX)) u_sec (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .ld_i(ld), .ld_val_i(sec_ld),
    .en_i(cs_co), .down_i(dir), .val_o(time_bcd[SEC_LSB +: 8]), .co_o(sec_co)
  );

  bcd_digit_pair #(.MAX_BCD(MAX_MIN_BCD)) u_min (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .ld_i(ld), .ld_val_i(min_ld),
    .en_i(sec_co), .down_i(dir), .val_o(time_bcd[MIN_LSB +: 8]), .co_o(min_co)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      STOPPED: begin
        if (run && !(dir && zero)) state_d = RUNNING;
      end
      RUNNING: begin
        if (!run) begin
          state_d = STOPPED;
        end else if (tick && dir && (zero || is_one)) begin
          state_d = EXPIRED;
          done_d  = 1'b1;
        end else if (!dir && min_co) begin
          wrap_d = 1'b1;
        end
      end
      EXPIRED: begin
        if (!run || clr || ld) state_d = STOPPED;
      end
      default: state_d = STOPPED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STOPPED;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign running = (state_q == RUNNING);
  assign done    = done_q;
  assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
  logic [23:0] lap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      lap_q <= 24'h000000;
    else if (clr) lap_q <= 24'h000000;
    else if (lap) lap_q <= time_bcd;
  end

  assign lap_bcd = lap_q;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign lap_bcd    = time_bcd;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - directed self-checking bench for stopwatch_core
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce100 = 1'b0;
  logic        clr = 1'b0;
  logic        ld = 1'b0;
  logic        dir = 1'b0;
  logic        run = 1'b0;
  logic [23:0] load_bcd = 24'h0;
  logic        lap = 1'b0;
  logic [23:0] time_bcd;
  logic [23:0] lap_bcd;
  logic        zero;
  logic        running;
  logic        done;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  stopwatch_core #(.MAX_MIN_BCD(8'h59)) dut (
    .clk(clk), .rst(rst), .ce100(ce100), .clr(clr), .ld(ld), .dir(dir), .run(run),
    .load_bcd(load_bcd), .lap(lap), .time_bcd(time_bcd), .lap_bcd(lap_bcd),
    .zero(zero), .running(running), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_value(input logic [23:0] v);
    ld = 1'b1;
    load_bcd = v;
    step();
    ld = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    rst = 1'b0;
    checks++; if (time_bcd !== 24'h0) begin errors++; $display("FAIL reset_time got %h exp %h", time_bcd, 24'h0); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
    load_value(24'h001233);
    run = 1'b1;
    step();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b exp 1", running); end
    ce100 = 1'b1;
    step();
    checks++; if (time_bcd !== 24'h001234) begin errors++; $display("FAIL pre_reset_time got %h exp %h", time_bcd, 24'h001234); end
    #2 rst = 1'b1;
    #1;
    checks++; if (time_bcd !== 24'h0) begin errors++; $display("FAIL async_reset_time got %h exp %h", time_bcd, 24'h0); end
    checks++; if (running !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      errors++; $display("FAIL async_reset_flags got r%b d%b w%b exp 000", running, done, wrap); end
    step();
    rst = 1'b0;
    run = 1'b0;
    ce100 = 1'b0;
    step();
  endtask

  task automatic test_up_carry();
    dir = 1'b0;
    load_value(24'h003499);
    run = 1'b1;
    step();
    ce100 = 1'b1;
    step();
    checks++; if (time_bcd !== 24'h003500) begin errors++; $display("FAIL up_carry1 got %h exp %h", time_bcd, 24'h003500); end
    step();
    checks++; if (time_bcd !== 24'h003501) begin errors++; $display("FAIL up_carry2 got %h exp %h", time_bcd, 24'h003501); end
    ce100 = 1'b0;
    run = 1'b0;
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL up_stop got %b exp 0", running); end
  endtask

  task automatic test_up_wrap();
    dir = 1'b0;
    load_value(24'h595999);
    run = 1'b1;
    step();
    ce100 = 1'b1;
    step();
    ce100 = 1'b0;
    checks++; if (time_bcd !== 24'h0) begin errors++; $display("FAIL wrap_time got %h exp %h", time_bcd, 24'h0); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %b exp 1", wrap); end
    step();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle got %b exp 0", wrap); end
    checks++; if (time_bcd !== 24'h0) begin errors++; $display("FAIL wrap_hold got %h exp %h", time_bcd, 24'h0); end
    run = 1'b0;
    step();
  endtask

  task automatic test_down();
    dir = 1'b1;
    load_value(24'h000002);
    run = 1'b1;
    step();
    ce100 = 1'b1;
    step();
    checks++; if (time_bcd !== 24'h000001 || done !== 1'b0) begin
      errors++; $display("FAIL down1 got %h d%b exp 000001 d0", time_bcd, done); end
    step();
    checks++; if (time_bcd !== 24'h0 || done !== 1'b1) begin
      errors++; $display("FAIL down_done got %h d%b exp 000000 d1", time_bcd, done); end
    checks++; if (running !== 1'b0 || zero !== 1'b1) begin
      errors++; $display("FAIL down_expired got r%b z%b exp r0 z1", running, zero); end
    step();
    checks++; if (time_bcd !== 24'h0 || done !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL down_hold got %h d%b r%b exp 000000 d0 r0", time_bcd, done, running); end
    ce100 = 1'b0;
    run = 1'b0;
    step();
    run = 1'b1;
    dir = 1'b0;
    step();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL expired_to_stopped got %b exp 1", running); end
    run = 1'b0;
    step();
  endtask

  task automatic test_clamp_priority();
    dir = 1'b0;
    load_value(24'h7A6F9C);
    checks++; if (time_bcd !== 24'h595999) begin errors++; $display("FAIL clamp got %h exp %h", time_bcd, 24'h595999); end
    run = 1'b1;
    step();
    clr = 1'b1;
    ld = 1'b1;
    load_bcd = 24'h123456;
    ce100 = 1'b1;
    step();
    clr = 1'b0;
    ld = 1'b0;
    ce100 = 1'b0;
    checks++; if (time_bcd !== 24'h0 || running !== 1'b1) begin
      errors++; $display("FAIL clr_ld_tick got %h r%b exp 000000 r1", time_bcd, running); end
    ce100 = 1'b1;
    load_value(24'h000100);
    checks++; if (time_bcd !== 24'h000100) begin errors++; $display("FAIL ld_drops_tick got %h exp %h", time_bcd, 24'h000100); end
    step();
    checks++; if (time_bcd !== 24'h000101) begin errors++; $display("FAIL ld_then_count got %h exp %h", time_bcd, 24'h000101); end
    ce100 = 1'b0;
    dir = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    ce100 = 1'b1;
    step();
    ce100 = 1'b0;
    checks++; if (time_bcd !== 24'h0 || done !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL clr_down got %h d%b r%b exp 000000 d1 r0", time_bcd, done, running); end
    run = 1'b0;
    dir = 1'b0;
    step();
  endtask

  task automatic test_lap();
    dir = 1'b0;
    run = 1'b1;
    load_value(24'h010202);
    ce100 = 1'b1;
    step();
    checks++; if (time_bcd !== 24'h010203) begin errors++; $display("FAIL lap_pre got %h exp %h", time_bcd, 24'h010203); end
    lap = 1'b1;
    step();
    lap = 1'b0;
    ce100 = 1'b0;
    checks++; if (time_bcd !== 24'h010204) begin errors++; $display("FAIL lap_time got %h exp %h", time_bcd, 24'h010204); end
`ifdef STOPWATCH_LAP_EN
    checks++; if (lap_bcd !== 24'h010203) begin errors++; $display("FAIL lap_capture got %h exp %h", lap_bcd, 24'h010203); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (lap_bcd !== 24'h0) begin errors++; $display("FAIL lap_clr got %h exp %h", lap_bcd, 24'h0); end
`else
    checks++; if (lap_bcd !== 24'h010204) begin errors++; $display("FAIL lap_follow got %h exp %h", lap_bcd, 24'h010204); end
`endif
    run = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_up_carry();
    test_up_wrap();
    test_down();
    test_clamp_priority();
    test_lap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
